// File: rtl/spi_fword_pkg.sv
// Shared constants, FSM encoding and frame timing helper for the SPI fword master.
package spi_fword_pkg;

    localparam logic [7:0] CMD_FWORD     = 8'h01;
    localparam int         NUM_BYTES     = 5;
    localparam int         BYTE_W        = 8;
    localparam int         BIT_IDX_W     = $clog2(BYTE_W);
    localparam int         BYTE_IDX_W    = $clog2(NUM_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        BIT_LO,
        BIT_HI,
        GAP,
        HOLD
    } state_e;

    // Number of clk cycles cs is held low for one frame.
    function automatic int frame_cs_low(input int clk_div, input int cs_setup,
                                        input int ibg, input int cs_hold);
        return cs_setup + NUM_BYTES * BYTE_W * 2 * clk_div + (NUM_BYTES - 1) * ibg + cs_hold;
    endfunction

    localparam int FRAME_CS_LOW_DEFAULT = frame_cs_low(4, 2, 8, 2);

endpackage

// File: rtl/spi_byte_shifter.sv
// 8-bit SPI mode-0 shift engine: divides clk into SCK half-periods, shifts mosi
// out MSB first on falling edges and captures miso as SCK rises.
module spi_byte_shifter
    import spi_fword_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_byte,
    input  logic              go,
    input  logic              miso_s,
    output logic              sck,
    output logic              mosi,
    output logic              half_end,
    output logic              byte_done,
    output logic [BYTE_W-1:0] rx_byte
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic                 active_q, active_d;
    logic                 phase_q, phase_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    logic [BYTE_W-1:0]    tx_q, tx_d;
    logic [BYTE_W-1:0]    rx_q, rx_d;

    assign half_end  = active_q && (div_q == DIV_W'(CLK_DIV - 1));
    assign byte_done = half_end && phase_q && (bit_q == '0);
    assign sck       = phase_q;
    assign mosi      = tx_q[BYTE_W-1];
    assign rx_byte   = rx_q;

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (load) begin
            tx_d = load_byte;
        end
        if (go) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            div_d    = '0;
            bit_d    = BIT_IDX_W'(BYTE_W - 1);
        end else if (active_q) begin
            if (half_end) begin
                div_d = '0;
                if (!phase_q) begin
                    // Rising edge: synchronised miso has settled since the last fall.
                    phase_d = 1'b1;
                    rx_d    = {rx_q[BYTE_W-2:0], miso_s};
                end else begin
                    phase_d = 1'b0;
                    if (bit_q == '0) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d = bit_q - 1'b1;
                        tx_d  = {tx_q[BYTE_W-2:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

endmodule

// File: rtl/spi_fword_master.sv
// SPI mode-0 master sending {0x01, fword LSB..MSB} as one cs frame and checking
// the slave's prev+1 echo replies.
module spi_fword_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int IBG      = 8,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fword,
    output logic        busy,
    output logic        done,
    output logic        echo_ok,
    output logic        cmd_hazard,
    output logic        sck,
    output logic        cs,
    output logic        mosi,
    input  logic        miso
);
    import spi_fword_pkg::*;

    localparam int CNT_MAX = (IBG > CS_SETUP) ? ((IBG > CS_HOLD) ? IBG : CS_HOLD)
                                              : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]    frame_q, frame_d;
    logic [BYTE_IDX_W-1:0]               byte_q, byte_d;
    logic                                ok_q, ok_d;
    logic                                echo_ok_q, echo_ok_d;
    logic                                hazard_q, hazard_d;
    logic                                done_q, done_d;
    logic                                busy_q, busy_d;
    logic                                cs_q, cs_d;
    logic [1:0]                          sync_q, sync_d;

    logic                                sh_load, sh_go;
    logic [BYTE_W-1:0]                   sh_byte;
    logic                                sh_half_end, sh_byte_done;
    logic [BYTE_W-1:0]                   sh_rx;
    logic [BYTE_IDX_W-1:0]               prev_idx;
    logic [BYTE_W-1:0]                   echo_exp;
    logic                                payload_hazard;

    assign sync_d   = {sync_q[0], miso};
    assign prev_idx = (byte_q == '0) ? '0 : byte_q - 1'b1;
    assign echo_exp = frame_q[prev_idx] + 8'd1;

    always_comb begin
        payload_hazard = 1'b0;
        for (int i = 1; i < NUM_BYTES; i++) begin
            if (frame_q[i] == CMD_FWORD) payload_hazard = 1'b1;
        end
    end

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .rst_n     (rst),
        .load      (sh_load),
        .load_byte (sh_byte),
        .go        (sh_go),
        .miso_s    (sync_q[1]),
        .sck       (sck),
        .mosi      (mosi),
        .half_end  (sh_half_end),
        .byte_done (sh_byte_done),
        .rx_byte   (sh_rx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        byte_d    = byte_q;
        ok_d      = ok_q;
        echo_ok_d = echo_ok_q;
        hazard_d  = hazard_q;
        done_d    = 1'b0;
        sh_load   = 1'b0;
        sh_go     = 1'b0;
        sh_byte   = frame_q[byte_q];
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    frame_d = {fword, CMD_FWORD};
                    sh_load = 1'b1;
                    sh_byte = CMD_FWORD;
                    byte_d  = '0;
                    cnt_d   = '0;
                    ok_d    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    sh_go   = 1'b1;
                    state_d = BIT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BIT_LO: begin
                if (sh_half_end) state_d = BIT_HI;
            end
            BIT_HI: begin
                if (sh_byte_done) begin
                    // Reply during byte 0 carries nothing the slave has seen yet.
                    if (byte_q != '0 && sh_rx != echo_exp) ok_d = 1'b0;
                    cnt_d = '0;
                    if (byte_q == BYTE_IDX_W'(NUM_BYTES - 1)) begin
                        state_d = HOLD;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = GAP;
                    end
                end else if (sh_half_end) begin
                    state_d = BIT_LO;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(IBG - 1)) begin
                    cnt_d   = '0;
                    sh_load = 1'b1;
                    sh_go   = 1'b1;
                    state_d = BIT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    echo_ok_d = ok_q;
                    hazard_d  = payload_hazard;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        cs_d   = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            frame_q   <= '0;
            byte_q    <= '0;
            ok_q      <= 1'b0;
            echo_ok_q <= 1'b0;
            hazard_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cs_q      <= 1'b1;
            sync_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            byte_q    <= byte_d;
            ok_q      <= ok_d;
            echo_ok_q <= echo_ok_d;
            hazard_q  <= hazard_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cs_q      <= cs_d;
            sync_q    <= sync_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign echo_ok    = echo_ok_q;
    assign cmd_hazard = hazard_q;
    assign cs         = cs_q;

endmodule

// File: tb/tb_spi_fword_master.sv
// Directed bench for spi_fword_master with a cycle-sampled SPI slave echo model.
`timescale 1ns/1ps
module tb_spi_fword_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] fword;
    logic        busy, done, echo_ok, cmd_hazard, sck, cs, mosi;
    logic        miso = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    spi_fword_master dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fword      (fword),
        .busy       (busy),
        .done       (done),
        .echo_ok    (echo_ok),
        .cmd_hazard (cmd_hazard),
        .sck        (sck),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 clk = ~clk;

    // Slave model: replies to each byte with (received byte + 1), optionally corrupting byte 3.
    logic       cs_prev = 1'b1, sck_prev = 1'b0;
    logic [7:0] s_rx = '0, s_tx = '0, s_reply = '0;
    int         s_bit = 0, s_nbytes = 0;
    bit         s_pend = 0;
    bit         corrupt = 0;
    logic [7:0] rxb [5];
    int         cs_low = 0, rises = 0, cs_hi = 0, last_gap = 0;

    always @(negedge clk) begin
        if (!cs && cs_prev) begin
            last_gap = cs_hi;
            cs_hi    = 0;
            cs_low   = 0;
            rises    = 0;
            s_bit    = 0;
            s_nbytes = 0;
            s_pend   = 0;
            for (int i = 0; i < 5; i++) rxb[i] = 8'h00;
            s_tx = 8'hA5;
            miso = s_tx[7];
        end
        if (cs) cs_hi++;
        else    cs_low++;
        if (!cs && sck && !sck_prev) begin
            rises++;
            s_rx = {s_rx[6:0], mosi};
            s_bit++;
            if (s_bit == 8) begin
                if (s_nbytes < 5) rxb[s_nbytes] = s_rx;
                s_nbytes++;
                s_bit   = 0;
                s_reply = (corrupt && s_nbytes == 3) ? 8'h00 : s_rx + 8'd1;
                s_pend  = 1;
            end
        end
        if (!cs && !sck && sck_prev) begin
            if (s_pend) begin
                s_tx   = s_reply;
                s_pend = 0;
            end else begin
                s_tx = {s_tx[6:0], 1'b0};
            end
            miso = s_tx[7];
        end
        cs_prev  = cs;
        sck_prev = sck;
    end

    function automatic logic [39:0] rx_word();
        return {rxb[0], rxb[1], rxb[2], rxb[3], rxb[4]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        fword = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [39:0] exp_bytes, input logic exp_ok,
                             input logic exp_haz, input bit chain, input logic [31:0] next_w);
        int n = 0;
        while (done !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check({tag, ":done_seen"}, 64'(done), 64'(1));
        check({tag, ":busy_at_done"}, 64'(busy), 64'(0));
        check({tag, ":cs_at_done"}, 64'(cs), 64'(1));
        check({tag, ":echo_ok"}, 64'(echo_ok), 64'(exp_ok));
        check({tag, ":cmd_hazard"}, 64'(cmd_hazard), 64'(exp_haz));
        check({tag, ":mosi_bytes"}, 64'(rx_word()), 64'(exp_bytes));
        check({tag, ":cs_low_cycles"}, 64'(cs_low), 64'(356));
        check({tag, ":sck_rises"}, 64'(rises), 64'(40));
        if (chain) begin
            fword = next_w;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        check({tag, ":done_one_cycle"}, 64'(done), 64'(0));
    endtask

    initial begin
        int idle_bad;
        rst   = 1'b0;
        start = 1'b0;
        fword = '0;
        #1;
        repeat (3) tick();
        check("rst:cs", 64'(cs), 64'(1));
        check("rst:sck", 64'(sck), 64'(0));
        check("rst:mosi", 64'(mosi), 64'(0));
        check("rst:busy", 64'(busy), 64'(0));
        check("rst:done", 64'(done), 64'(0));
        check("rst:echo_ok", 64'(echo_ok), 64'(0));
        check("rst:cmd_hazard", 64'(cmd_hazard), 64'(0));
        rst = 1'b1;

        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cs !== 1'b1 || sck !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
        end
        check("idle:bad_cycles", 64'(idle_bad), 64'(0));

        // Frame A: nominal word, clean echoes.
        send(32'hC5B09928);
        check("A:busy_after_start", 64'(busy), 64'(1));
        check("A:cs_after_start", 64'(cs), 64'(0));
        check("A:mosi_first_bit", 64'(mosi), 64'(0));
        wait_done("A", 40'h01_28_99_B0_C5, 1'b1, 1'b0, 0, '0);

        // Frame B: reply to byte 3 corrupted.
        tick();
        corrupt = 1;
        send(32'hC5B09928);
        wait_done("B", 40'h01_28_99_B0_C5, 1'b0, 1'b0, 0, '0);
        corrupt = 0;

        // Frame C: payload contains the command byte.
        tick();
        send(32'h00010203);
        wait_done("C", 40'h01_03_02_01_00, 1'b1, 1'b1, 0, '0);
        check("C:echo_held", 64'(echo_ok), 64'(1));

        // Frame D: start during frame ignored, then back-to-back start in the done cycle.
        tick();
        send(32'hC5B09928);
        repeat (49) tick();
        send(32'hFFFFFFFF);
        check("D:busy_after_ignored_start", 64'(busy), 64'(1));
        wait_done("D", 40'h01_28_99_B0_C5, 1'b1, 1'b0, 1, 32'hA1B2C3D4);
        check("E:busy_b2b", 64'(busy), 64'(1));
        check("E:cs_b2b", 64'(cs), 64'(0));
        wait_done("E", 40'h01_D4_C3_B2_A1, 1'b1, 1'b0, 0, '0);
        check("E:cs_high_gap", 64'(last_gap), 64'(1));

        // Frame F: reset mid-frame, then a clean frame.
        tick();
        send(32'hC5B09928);
        repeat (119) tick();
        check("F:busy_before_rst", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("F:cs_async", 64'(cs), 64'(1));
        check("F:sck_async", 64'(sck), 64'(0));
        check("F:busy_async", 64'(busy), 64'(0));
        check("F:mosi_async", 64'(mosi), 64'(0));
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        check("F:idle_after_rst", 64'(cs), 64'(1));
        send(32'h12345678);
        wait_done("G", 40'h01_78_56_34_12, 1'b1, 1'b0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_fword_master.md
Name: spi_fword_master

Overview:
SPI mode-0 master that delivers a 32-bit DDS frequency word to the FPGA's SPI slave frame loader. One frame is the sync/command byte 0x01 followed by the four fword bytes, least-significant byte first. Bits within each byte go MSB first. The block checks the slave's echo replies, where each reply is the previous received byte + 1. It is used as the on-chip loopback/bring-up driver and as the reference initiator for the external controller.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period (>=2)
CS_SETUP, 2, clk cycles from cs fall to first SCK rise edge window start
IBG, 8, inter-byte gap in clk cycles, SCK low, cs held low
CS_HOLD, 2, clk cycles from last SCK fall to cs rise

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only when busy=0
fword  in  32  frequency word; latched on accepted start
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end
echo_ok  out  1  valid with done: all four echo checks passed
cmd_hazard  out  1  valid with done: some payload byte equals 0x01
sck  out  1  SPI clock, idle low
cs  out  1  chip select, active low
mosi  out  1  master data out
miso  in  1  slave data in (synchronised internally, 2 flops)

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-low.
- Reset values: sck=0, cs=1, mosi=0, busy=0, done=0, echo_ok=0, cmd_hazard=0, state=IDLE.
- Reset asserted mid-frame: outputs go to reset values immediately (async). No partial-frame recovery.
- FSM states: IDLE -> SETUP -> BIT_LO -> BIT_HI -> (next bit: BIT_LO | byte end: GAP or HOLD) -> GAP -> BIT_LO ... -> HOLD -> IDLE.
- IDLE: when start=1 and busy=0:
  - latch the frame {0x01, fword[7:0], fword[15:8], fword[23:16], fword[31:24]}
  - on the next cycle: busy=1, cs=0, mosi=MSB of 0x01; enter SETUP.
- start while busy=1 is ignored. The latched word is not disturbed by fword changes during a frame.
- SETUP: hold CS_SETUP cycles, then BIT_LO.
- BIT_LO: sck=0 for CLK_DIV cycles, mosi = current bit (mosi changes only in the cycle sck falls or on entry).
- BIT_HI: sck=1 for CLK_DIV cycles. The miso sample is taken in the cycle sck rises, using the synchronised value delayed by the sync latency.
- Bit and byte counters:
  - after bit 0 of a byte, sck returns low;
  - bytes 0-3 go to GAP (IBG cycles, cs low);
  - byte 4 goes to HOLD (CS_HOLD cycles), then cs=1.
- Frame end: done=1 for exactly one cycle, coincident with busy falling to 0 and cs rising to 1.
- A start in the cycle done=1 is accepted (back-to-back frames). cs stays high for at least 1 cycle between frames.
- Frame length with cs low = CS_SETUP + 80*CLK_DIV + 4*IBG + CS_HOLD (356 cycles at defaults).
- Echo check:
  - the byte received during byte k (k=1..4) must equal (sent byte k-1 + 1) mod 256;
  - the byte received during byte 0 is ignored;
  - echo_ok = AND of the four checks, updated at done, held until the next done.
- cmd_hazard: set at done if any of the four payload bytes == 0x01 (the slave resyncs on such a byte). The frame is still sent unchanged.
- No combinational path from miso to any output.

Decomposition:
- Package spi_fword_pkg contains:
  - CMD_FWORD = 8'h01
  - NUM_BYTES = 5
  - FSM state encoding
  - localparam for frame length formula used by the bench
- One sub-module: spi_byte_shifter. It is an 8-bit mode-0 shift engine with load/start, sck generation from CLK_DIV, mosi out, miso capture, and a byte_done pulse. The top handles cs, gaps, framing and echo checks.

Test Plan:
- Reset, then idle 20 cycles -> cs=1, sck=0, busy=0, done=0 throughout.
- start with fword=0xC5B09928; slave model echoes prev+1:
  - MOSI decodes bytes 01,28,99,B0,C5 MSB-first;
  - cs low exactly 356 cycles; 40 sck rising edges;
  - done pulses once; echo_ok=1, cmd_hazard=0.
- Same word, slave model corrupts the reply to byte 3 (returns 0x00 instead of 0x9A) -> echo_ok=0 at done; frame timing unchanged.
- fword=0x00010203 -> bytes 01,03,02,01,00; cmd_hazard=1, echo_ok=1.
- start pulsed at cycle 50 of an active frame with fword=0xFFFFFFFF -> ignored; MOSI still carries the first word. A start in the done cycle launches a second frame with cs high for exactly 1 cycle between frames.
- rst asserted at cycle 120 of a frame -> cs=1, sck=0, busy=0 asynchronously. After release, a new start with 0x12345678 sends 01,78,56,34,12 correctly.
